// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one backing-memory port between
// an instruction-side and a data-side requester, with a BUSY-cycle timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_wenable,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        d_req,
  input  logic        d_wenable,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        i_stall,
  output logic        i_done,
  output logic        i_err,
  output logic [31:0] i_rdata,
  output logic        d_stall,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wenable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]    state;
  logic          gnt;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          pick_d;
  logic          hit_to;
  // gnt/last_grant: 1 = data side, 0 = instruction side
  always_comb begin
    pick_d = d_req & (~i_req | ~last_grant);
    hit_to = cnt == CW'(TIMEOUT - 1);
  end
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      mem_req     <= 1'b0;
      mem_wenable <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_done      <= 1'b0;
      i_err       <= 1'b0;
      i_rdata     <= '0;
      d_done      <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
    end else begin
      case (state)
        IDLE: if (i_req | d_req) begin
          gnt         <= pick_d;
          mem_req     <= 1'b1;
          mem_wenable <= pick_d ? d_wenable : i_wenable;
          mem_addr    <= pick_d ? d_addr : i_addr;
          mem_wdata   <= pick_d ? d_wdata : i_wdata;
          cnt         <= '0;
          state       <= BUSY;
        end
        // the TIMEOUT-th ack-less cycle aborts; an ack in that cycle still wins
        BUSY: if (mem_ack || hit_to) begin
          mem_req <= 1'b0;
          i_done  <= ~gnt;
          d_done  <= gnt;
          i_err   <= ~gnt & ~mem_ack;
          d_err   <= gnt & ~mem_ack;
          if (gnt) d_rdata <= mem_ack ? mem_rdata : '0;
          else i_rdata <= mem_ack ? mem_rdata : '0;
          state   <= DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          i_done     <= 1'b0;
          d_done     <= 1'b0;
          i_err      <= 1'b0;
          d_err      <= 1'b0;
          last_grant <= gnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
